// File: rtl/tlb_search_arbiter.sv
// rtl/tlb_search_arbiter.sv - arbitrates the shared TLB search port between tlbp, DTLB and ITLB refill
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   p_req/p_vpn2/p_asid            tlbp search request (requester 0)
//   d_req/d_vaddr                  DTLB buffer miss request (requester 1)
//   i_req/i_vaddr                  ITLB buffer miss request (requester 2)
//   cur_asid                       ASID used for d/i lookups
//   *_gnt                          same-cycle grant pulse
//   *_resp_valid                   one-cycle result strobe to the owner
//   r_found..r_v                   registered search result
//   s_vpn2/s_odd_page/s_asid       key to the TLB search port
//   s_found..s_v                   result from the TLB search port
//   flush, tlb_wr                  pipeline flush, TLB array written
//   perf_i_miss, perf_d_miss       miss counters, present only with TLB_ARB_PERF_EN defined
module tlb_search_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_req,
    input  logic [18:0] p_vpn2,
    input  logic [7:0]  p_asid,
    input  logic        d_req,
    input  logic [31:0] d_vaddr,
    input  logic        i_req,
    input  logic [31:0] i_vaddr,
    input  logic [7:0]  cur_asid,
    output logic        p_gnt,
    output logic        d_gnt,
    output logic        i_gnt,
    output logic        p_resp_valid,
    output logic        d_resp_valid,
    output logic        i_resp_valid,
    output logic        r_found,
    output logic [3:0]  r_index,
    output logic [19:0] r_pfn,
    output logic [2:0]  r_c,
    output logic        r_d,
    output logic        r_v,
    output logic [18:0] s_vpn2,
    output logic        s_odd_page,
    output logic [7:0]  s_asid,
    input  logic        s_found,
    input  logic [3:0]  s_index,
    input  logic [19:0] s_pfn,
    input  logic [2:0]  s_c,
    input  logic        s_d,
    input  logic        s_v,
    input  logic        flush,
    input  logic        tlb_wr,
    output logic [31:0] perf_i_miss,
    output logic [31:0] perf_d_miss
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic [1:0] OWN_P = 2'd0;
    localparam logic [1:0] OWN_D = 2'd1;
    localparam logic [1:0] OWN_I = 2'd2;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t      state;
    logic [1:0]  owner;
    logic [3:0]  starve_cnt;
    logic [18:0] key_vpn2;
    logic        key_odd;
    logic [7:0]  key_asid;

    logic arb_ok, i_forced, pick_p, pick_d, pick_i, deliver;

    always_comb begin
        // gnt is combinational so the request is accepted in the cycle it is seen
        arb_ok   = (state == IDLE) && !flush && !reset;
        i_forced = i_req && (starve_cnt == LIMIT);
        pick_p   = arb_ok && p_req;
        pick_i   = arb_ok && !p_req && i_req && (!d_req || i_forced);
        pick_d   = arb_ok && !p_req && d_req && !i_forced;
        // a write or flush landing in RESP cancels the delivery
        deliver  = (state == RESP) && !flush && !tlb_wr;
    end

    assign p_gnt        = pick_p;
    assign d_gnt        = pick_d;
    assign i_gnt        = pick_i;
    assign p_resp_valid = deliver && (owner == OWN_P);
    assign d_resp_valid = deliver && (owner == OWN_D);
    assign i_resp_valid = deliver && (owner == OWN_I);

    assign s_vpn2     = key_vpn2;
    assign s_odd_page = key_odd;
    assign s_asid     = key_asid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_P;
            starve_cnt <= '0;
            key_vpn2   <= '0;
            key_odd    <= 1'b0;
            key_asid   <= '0;
            r_found    <= 1'b0;
            r_index    <= '0;
            r_pfn      <= '0;
            r_c        <= '0;
            r_d        <= 1'b0;
            r_v        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_p) begin
                        owner    <= OWN_P;
                        key_vpn2 <= p_vpn2;
                        key_odd  <= 1'b0;
                        key_asid <= p_asid;
                        state    <= LOOKUP;
                    end else if (pick_i) begin
                        owner      <= OWN_I;
                        key_vpn2   <= i_vaddr[31:13];
                        key_odd    <= i_vaddr[12];
                        key_asid   <= cur_asid;
                        starve_cnt <= '0;
                        state      <= LOOKUP;
                    end else if (pick_d) begin
                        owner    <= OWN_D;
                        key_vpn2 <= d_vaddr[31:13];
                        key_odd  <= d_vaddr[12];
                        key_asid <= cur_asid;
                        if (i_req && (starve_cnt < LIMIT))
                            starve_cnt <= starve_cnt + 4'd1;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (!tlb_wr) begin
                        // a write this cycle may change the answer, so keep searching
                        r_found <= s_found;
                        r_index <= s_index;
                        r_pfn   <= s_pfn;
                        r_c     <= s_c;
                        r_d     <= s_d;
                        r_v     <= s_v;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (flush)
                        state <= IDLE;
                    else if (tlb_wr)
                        state <= LOOKUP;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TLB_ARB_PERF_EN
    logic [31:0] i_miss_q, d_miss_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_miss_q <= '0;
            d_miss_q <= '0;
        end else begin
            if (i_resp_valid && !r_found)
                i_miss_q <= i_miss_q + 32'd1;
            if (d_resp_valid && !r_found)
                d_miss_q <= d_miss_q + 32'd1;
        end
    end

    assign perf_i_miss = i_miss_q;
    assign perf_d_miss = d_miss_q;
`else
    assign perf_i_miss = '0;
    assign perf_d_miss = '0;
`endif

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// tb/tb_tlb_search_arbiter.sv - randomized, model-checked bench for tlb_search_arbiter
module tb_tlb_search_arbiter;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_req = 0, d_req = 0, i_req = 0;
    logic [18:0] p_vpn2 = '0;
    logic [7:0]  p_asid = '0, cur_asid = '0;
    logic [31:0] d_vaddr = '0, i_vaddr = '0;
    logic        p_gnt, d_gnt, i_gnt, p_resp_valid, d_resp_valid, i_resp_valid;
    logic        r_found, r_d, r_v;
    logic [3:0]  r_index;
    logic [19:0] r_pfn;
    logic [2:0]  r_c;
    logic [18:0] s_vpn2;
    logic        s_odd_page;
    logic [7:0]  s_asid;
    logic        s_found = 0, s_d = 0, s_v = 0;
    logic [3:0]  s_index = '0;
    logic [19:0] s_pfn = '0;
    logic [2:0]  s_c = '0;
    logic        flush = 0, tlb_wr = 0;
    logic [31:0] perf_i_miss, perf_d_miss;

    int n_cmp = 0;
    int n_fail = 0;

    tlb_search_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(rst),
        .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid),
        .d_req(d_req), .d_vaddr(d_vaddr), .i_req(i_req), .i_vaddr(i_vaddr),
        .cur_asid(cur_asid),
        .p_gnt(p_gnt), .d_gnt(d_gnt), .i_gnt(i_gnt),
        .p_resp_valid(p_resp_valid), .d_resp_valid(d_resp_valid), .i_resp_valid(i_resp_valid),
        .r_found(r_found), .r_index(r_index), .r_pfn(r_pfn), .r_c(r_c), .r_d(r_d), .r_v(r_v),
        .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
        .flush(flush), .tlb_wr(tlb_wr),
        .perf_i_miss(perf_i_miss), .perf_d_miss(perf_d_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: at most one search in flight, which either
    // still needs its search cycle (phase 1) or is ready to deliver (phase 2).
    bit          m_busy;
    int          m_owner, m_phase, m_cnt, mw;
    logic [18:0] m_vpn2;
    logic        m_odd;
    logic [7:0]  m_asid;
    logic        m_found, m_d, m_v;
    logic [3:0]  m_index;
    logic [19:0] m_pfn;
    logic [2:0]  m_c;
    logic [31:0] m_pi, m_pd;

    // -1 none, 0 tlbp, 1 data, 2 inst
    function automatic int model_winner();
        if (rst || m_busy || flush) return -1;
        if (p_req) return 0;
        if (i_req && (!d_req || m_cnt == STARVE)) return 2;
        if (d_req) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_owner = 0; m_phase = 0; m_cnt = 0;
            m_vpn2 = '0; m_odd = 0; m_asid = '0;
            m_found = 0; m_index = '0; m_pfn = '0; m_c = '0; m_d = 0; m_v = 0;
            m_pi = '0; m_pd = '0;
        end else if (!m_busy) begin
            mw = model_winner();
            if (mw >= 0) begin
                m_busy = 1; m_owner = mw; m_phase = 1;
                if (mw == 0) begin
                    m_vpn2 = p_vpn2; m_odd = 0; m_asid = p_asid;
                end else begin
                    m_vpn2 = (mw == 1) ? d_vaddr[31:13] : i_vaddr[31:13];
                    m_odd  = (mw == 1) ? d_vaddr[12] : i_vaddr[12];
                    m_asid = cur_asid;
                end
                if (mw == 2) m_cnt = 0;
                else if (mw == 1 && i_req && m_cnt < STARVE) m_cnt++;
            end
        end else if (flush) begin
            m_busy = 0;
        end else if (tlb_wr) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_found = s_found; m_index = s_index; m_pfn = s_pfn;
            m_c = s_c; m_d = s_d; m_v = s_v;
            m_phase = 2;
        end else begin
            if (!m_found && m_owner == 1) m_pd = m_pd + 1;
            if (!m_found && m_owner == 2) m_pi = m_pi + 1;
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int  w;
            bit  dv;
            w  = model_winner();
            dv = m_busy && m_phase == 2 && !flush && !tlb_wr;
            chk("p_gnt", p_gnt, w == 0);
            chk("d_gnt", d_gnt, w == 1);
            chk("i_gnt", i_gnt, w == 2);
            chk("p_resp_valid", p_resp_valid, dv && m_owner == 0);
            chk("d_resp_valid", d_resp_valid, dv && m_owner == 1);
            chk("i_resp_valid", i_resp_valid, dv && m_owner == 2);
            chk("r_result", {r_found, r_index, r_pfn, r_c, r_d, r_v},
                {m_found, m_index, m_pfn, m_c, m_d, m_v});
            chk("s_key", {s_vpn2, s_odd_page, s_asid}, {m_vpn2, m_odd, m_asid});
`ifdef TLB_ARB_PERF_EN
            chk("perf_i_miss", perf_i_miss, m_pi);
            chk("perf_d_miss", perf_d_miss, m_pd);
`else
            chk("perf_i_miss", perf_i_miss, 32'd0);
            chk("perf_d_miss", perf_d_miss, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int gp_c, gd_c, gi_c;
    int gseq[10];
    int gn;
    logic gp, gd, gi;

    initial begin
        tick(); tick();
        rst = 0;

        // single d request, odd page
        d_req = 1; d_vaddr = 32'h0040_3000; s_found = 1; s_pfn = 20'h1F00F; s_index = 4'd5;
        @(negedge clk); chk("t1_d_gnt_c0", d_gnt, 1);
        tick(); d_req = 0;
        @(negedge clk); chk("t1_s_vpn2", s_vpn2, 32'h201); chk("t1_s_odd", s_odd_page, 1);
        tick();
        @(negedge clk); chk("t1_resp_c2", d_resp_valid, 1); chk("t1_r_pfn", r_pfn, 32'h1F00F);
        tick();

        // all three together
        p_req = 1; d_req = 1; i_req = 1; gp_c = -1; gd_c = -1; gi_c = -1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            gp = p_gnt; gd = d_gnt; gi = i_gnt;
            if (gp) gp_c = c;
            if (gd) gd_c = c;
            if (gi) gi_c = c;
            tick();
            if (gp) p_req = 0;
            if (gd) d_req = 0;
            if (gi) i_req = 0;
        end
        chk("t2_p_gnt_cycle", gp_c, 0);
        chk("t2_d_gnt_cycle", gd_c, 3);
        chk("t2_i_gnt_cycle", gi_c, 6);

        // starvation: d and i held continuously
        d_req = 1; i_req = 1; gn = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (gn < 10 && d_gnt) begin gseq[gn] = 1; gn++; end
            if (gn < 10 && i_gnt) begin gseq[gn] = 2; gn++; end
            tick();
        end
        d_req = 0; i_req = 0;
        chk("t3_grant_count", gn, 10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("t3_grant%0d", k), gseq[k], (k % 5 == 4) ? 2 : 1);

        // flush during LOOKUP of an inst request
        i_req = 1; i_vaddr = 32'h1234_5000;
        @(negedge clk); chk("t4_i_gnt", i_gnt, 1);
        tick(); i_req = 0; d_req = 1; d_vaddr = 32'h8000_1000; flush = 1;
        @(negedge clk); chk("t4_no_i_resp_a", i_resp_valid, 0); chk("t4_no_d_gnt", d_gnt, 0);
        tick(); flush = 0;
        @(negedge clk); chk("t4_d_gnt", d_gnt, 1); chk("t4_no_i_resp_b", i_resp_valid, 0);
        tick(); d_req = 0;
        tick();
        @(negedge clk); chk("t4_d_resp", d_resp_valid, 1);
        tick();

        // tlb write during LOOKUP re-searches
        d_req = 1; d_vaddr = 32'h0ABC_D000; s_found = 0;
        @(negedge clk); chk("t5_d_gnt", d_gnt, 1);
        tick(); d_req = 0; tlb_wr = 1;
        tick(); tlb_wr = 0; s_found = 1;
        @(negedge clk); chk("t5_resp_delayed", d_resp_valid, 0);
        tick();
        @(negedge clk); chk("t5_resp", d_resp_valid, 1); chk("t5_r_found", r_found, 1);
        tick();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            gp = p_gnt; gd = d_gnt; gi = i_gnt;
            tick();
            if (!p_req || gp) begin
                p_req = ($urandom_range(0, 7) == 0);
                p_vpn2 = 19'($urandom); p_asid = 8'($urandom);
            end
            if (!d_req || gd) begin
                d_req = ($urandom_range(0, 3) != 0);
                d_vaddr = $urandom;
            end
            if (!i_req || gi) begin
                i_req = ($urandom_range(0, 2) != 0);
                i_vaddr = $urandom;
            end
            cur_asid = 8'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            tlb_wr   = ($urandom_range(0, 11) == 0);
            s_found  = $urandom_range(0, 1) == 1;
            s_index  = 4'($urandom); s_pfn = 20'($urandom); s_c = 3'($urandom);
            s_d = $urandom_range(0, 1) == 1; s_v = $urandom_range(0, 1) == 1;
        end

        // async reset while a response is being delivered
        p_req = 0; d_req = 0; i_req = 0; flush = 0; tlb_wr = 0;
        tick(); tick(); tick(); tick();
        d_req = 1; d_vaddr = 32'hFFFF_F000; s_found = 1; s_pfn = 20'hABCDE;
        @(negedge clk); chk("t6_d_gnt", d_gnt, 1);
        tick(); d_req = 0;
        tick();
        @(negedge clk); chk("t6_resp_before_reset", d_resp_valid, 1);
        rst = 1;
        #1;
        chk("t6_rst_resp", d_resp_valid, 0);
        chk("t6_rst_r", {r_found, r_index, r_pfn, r_c, r_d, r_v}, 32'd0);
        chk("t6_rst_s", {s_vpn2, s_odd_page, s_asid}, 32'd0);
        chk("t6_rst_perf", perf_i_miss | perf_d_miss, 32'd0);
        tick();
        rst = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tlb_search_arbiter.md
Name: tlb_search_arbiter

Overview:
- Shares the single combinational TLB search port between three requesters: CP0 tlbp (M1 stage), the DTLB buffer refill path and the ITLB buffer refill path.
- Registers the search key, performs the lookup in a dedicated cycle and returns a registered result to the winning requester.
- Handles pipeline flush and TLB writes (tlbwi/tlbwr/tlbr) that land mid-lookup.
- Sits between the TLB array and the ITLB/DTLB buffer stages plus CP0.

Parameters:
- STARVE_LIMIT, 4: consecutive data-side grants allowed while an inst request waits before inst is forced ahead of data (legal range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- p_req  in  1  tlbp search request (requester 0)
- p_vpn2  in  19  tlbp VPN2 (EntryHi)
- p_asid  in  8  tlbp ASID
- d_req  in  1  DTLB buffer miss request (requester 1)
- d_vaddr  in  32  data virtual address; [31:13] is VPN2, [12] is odd page
- i_req  in  1  ITLB buffer miss request (requester 2)
- i_vaddr  in  32  instruction virtual address
- cur_asid  in  8  CP0 EntryHi ASID, used for d/i lookups
- p_gnt, d_gnt, i_gnt  out  1 each  grant pulse; request accepted this cycle
- p_resp_valid, d_resp_valid, i_resp_valid  out  1 each  one-cycle result strobe
- r_found  out  1  registered search result: hit
- r_index  out  4  registered search result: matching entry index
- r_pfn  out  20  registered search result: PFN
- r_c  out  3  registered search result: cache attribute
- r_d  out  1  registered search result: dirty
- r_v  out  1  registered search result: valid
- s_vpn2  out  19  to TLB search port
- s_odd_page  out  1  to TLB search port
- s_asid  out  8  to TLB search port
- s_found  in  1  from TLB search port
- s_index  in  4  from TLB search port
- s_pfn  in  20  from TLB search port
- s_c  in  3  from TLB search port
- s_d  in  1  from TLB search port
- s_v  in  1  from TLB search port
- flush  in  1  pipeline flush (exception or eret)
- tlb_wr  in  1  TLB array written this cycle
- perf_i_miss  out  32  inst-side miss counter (optional feature)
- perf_d_miss  out  32  data-side miss counter (optional feature)

Behaviour:
- Reset (async): state IDLE, owner 0, all gnt and resp_valid 0, all r_* 0, s_* 0, starve_cnt 0, perf counters 0.
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - If flush is high, nothing is granted.
  - Otherwise the winner among asserted requests gets a gnt pulse in the same cycle. The key {vpn2, odd, asid} is latched and the state moves to LOOKUP.
  - For tlbp the key is {p_vpn2, 0, p_asid}. For d/i it is {vaddr[31:13], vaddr[12], cur_asid}.
- Priority:
  - p beats everything.
  - d beats i, except when starve_cnt == STARVE_LIMIT and i_req is high; then i beats d.
  - starve_cnt increments (saturating at STARVE_LIMIT) on each d grant while i_req is high. It clears on any i grant.
- LOOKUP:
  - s_* are driven from the latched key; s_* are held at the latched key in every state.
  - At the clock edge, s_found/index/pfn/c/d/v are captured into r_* and the state moves to RESP.
- RESP:
  - The owner's resp_valid is high for exactly one cycle and r_* are stable.
  - The state returns to IDLE, and arbitration resumes the next cycle, so there are no back-to-back grants.
- Latency: request accepted in cycle N; resp_valid in cycle N+2; next grant no earlier than N+3.
- Requesters hold req until gnt. Holding req past gnt is a new request.
- flush in LOOKUP or RESP: resp_valid is suppressed that cycle and the state goes to IDLE. This applies to all owners.
- tlb_wr in LOOKUP or RESP (without flush): resp_valid is suppressed, r_* are not updated and the state goes back to LOOKUP to re-search with the same key. This repeats while tlb_wr stays high.
- flush and tlb_wr together: flush wins.
- r_* hold their last values outside RESP.

Optional Feature:
- Macro TLB_ARB_PERF_EN.
- Defined: perf_i_miss and perf_d_miss increment by 1 on each delivered i/d resp_valid with r_found == 0. They wrap from 0xFFFFFFFF to 0. Suppressed responses do not count.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Single d request, d_vaddr=0x0040_3000, TLB returns found=1, pfn=0x1F00F -> d_gnt in cycle 0; d_resp_valid in cycle 2 with r_pfn=0x1F00F; s_odd_page=1.
- p_req, d_req and i_req asserted together -> p_gnt first; then d_gnt at cycle 3, i_gnt at cycle 6; each resp_valid 2 cycles after its gnt.
- d_req and i_req held continuously with STARVE_LIMIT=4 -> four d grants, then an i grant, then starve_cnt=0 and the pattern repeats.
- flush pulsed in LOOKUP of an i request -> no i_resp_valid; state IDLE next cycle; a pending d_req is granted the cycle after flush deasserts.
- tlb_wr in LOOKUP, TLB result changes from found=0 to found=1 -> resp delayed one cycle, delivered with r_found=1.
- TLB_ARB_PERF_EN defined, 3 d misses and 1 d hit -> perf_d_miss=3, perf_i_miss=0. Async reset mid-RESP -> all outputs 0 immediately.
